// File: rtl/elevator_car.sv
// Per-car motion and door controller: walks the car floor by floor toward its
// assigned hall calls and latched cabin requests, stopping to open the door.
module elevator_car #(
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3,
  parameter int RESET_FLOOR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] floorButtonIn,
  input  logic [6:0]  cabinButton,
  output logic [2:0]  currentFloor,
  output logic [1:0]  direction,
  output logic [13:0] floorButtonOut,
  output logic [6:0]  cabinPending,
  output logic        doorOpen
);
  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;

  state_e          state_q;
  logic [2:0]      floor_q;
  logic [1:0]      dir_q;
  logic            door_q;
  logic [MW-1:0]   mcnt_q;
  logic [DW-1:0]   dcnt_q;
  logic [13:0]     hall_q;
  logic [6:0]      cab_q;

  logic [6:0]  hall_up, hall_dn, req, cur_oh, step_oh;
  logic [6:0]  clr_up, clr_dn, clr_cab, cab_d;
  logic [13:0] clr_hall, hall_d;
  logic [2:0]  floor_step;
  logic        above_cur, below_cur, beyond_step, here_req;
  logic        arrive, stop_arr, door_hit, match_up, match_dn, go_up, go_dn;

  // Bit gi of each per-floor vector stands for floor gi+1.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_floor
      assign hall_up[gi]        = floorButtonIn[2*gi+1];
      assign hall_dn[gi]        = floorButtonIn[2*gi];
      assign req[gi]            = cab_q[gi] | hall_up[gi] | hall_dn[gi];
      assign clr_hall[2*gi+1]   = clr_up[gi];
      assign clr_hall[2*gi]     = clr_dn[gi];
    end
  endgenerate

  function automatic logic any_above(input logic [6:0] r, input logic [2:0] f);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 7; i++) if (i >= int'(f)) a = a | r[i];
    return a;
  endfunction

  function automatic logic any_below(input logic [6:0] r, input logic [2:0] f);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 7; i++) if (i + 1 < int'(f)) b = b | r[i];
    return b;
  endfunction

  always_comb begin
    cur_oh      = 7'(7'd1 << (floor_q - 3'd1));
    floor_step  = (dir_q == DIR_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
    step_oh     = 7'(7'd1 << (floor_step - 3'd1));
    above_cur   = any_above(req, floor_q);
    below_cur   = any_below(req, floor_q);
    beyond_step = (dir_q == DIR_UP) ? any_above(req, floor_step) : any_below(req, floor_step);
    here_req    = |(req & cur_oh);
    arrive      = (state_q == S_MOVE) && (mcnt_q == MOVE_LAST);
    stop_arr    = (|(cab_q & step_oh)) | !beyond_step |
                  ((dir_q == DIR_UP) ? (|(hall_up & step_oh)) : (|(hall_dn & step_oh)));
    // A stationary door (entered from IDLE) accepts calls in either direction.
    match_up    = (dir_q != DIR_DOWN);
    match_dn    = (dir_q != DIR_UP);
    door_hit    = (state_q == S_DOOR) &&
                  ((|((cab_q | cabinButton) & cur_oh)) |
                   (match_up && (|(hall_up & cur_oh))) |
                   (match_dn && (|(hall_dn & cur_oh))));
    go_up       = above_cur && ((dir_q != DIR_DOWN) || !below_cur);
    go_dn       = below_cur && ((dir_q == DIR_DOWN) || !above_cur);

    clr_up  = '0;
    clr_dn  = '0;
    clr_cab = '0;
    case (state_q)
      S_IDLE: if (here_req) begin
        clr_up  = cur_oh;
        clr_dn  = cur_oh;
        clr_cab = cur_oh;
      end
      S_MOVE: if (arrive && stop_arr) begin
        clr_cab = step_oh;
        if (dir_q == DIR_UP || !beyond_step) clr_up = step_oh;
        if (dir_q == DIR_DOWN || !beyond_step) clr_dn = step_oh;
      end
      S_DOOR: if (door_hit) begin
        clr_cab = cur_oh;
        if (match_up) clr_up = cur_oh;
        if (match_dn) clr_dn = cur_oh;
      end
      default: ;
    endcase

    hall_d = floorButtonIn & ~clr_hall;
    cab_d  = (cab_q | cabinButton) & ~clr_cab;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      floor_q <= 3'(RESET_FLOOR);
      dir_q   <= DIR_STOP;
      door_q  <= 1'b0;
      mcnt_q  <= '0;
      dcnt_q  <= '0;
      hall_q  <= '0;
      cab_q   <= '0;
    end else begin
      hall_q <= hall_d;
      cab_q  <= cab_d;
      case (state_q)
        S_IDLE: begin
          dir_q <= DIR_STOP;
          if (here_req) begin
            state_q <= S_DOOR;
            door_q  <= 1'b1;
            dcnt_q  <= '0;
          end else if (above_cur || below_cur) begin
            state_q <= S_MOVE;
            dir_q   <= above_cur ? DIR_UP : DIR_DOWN;
            mcnt_q  <= '0;
          end
        end
        S_MOVE: begin
          if (arrive) begin
            floor_q <= floor_step;
            mcnt_q  <= '0;
            if (stop_arr) begin
              state_q <= S_DOOR;
              door_q  <= 1'b1;
              dcnt_q  <= '0;
            end
          end else begin
            mcnt_q <= mcnt_q + 1'b1;
          end
        end
        S_DOOR: begin
          if (door_hit) begin
            dcnt_q <= '0;
          end else if (dcnt_q == DOOR_LAST) begin
            door_q <= 1'b0;
            mcnt_q <= '0;
            if (go_up) begin
              state_q <= S_MOVE;
              dir_q   <= DIR_UP;
            end else if (go_dn) begin
              state_q <= S_MOVE;
              dir_q   <= DIR_DOWN;
            end else begin
              state_q <= S_IDLE;
              dir_q   <= DIR_STOP;
            end
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign currentFloor   = floor_q;
  assign direction      = dir_q;
  assign floorButtonOut = hall_q;
  assign cabinPending   = cab_q;
  assign doorOpen       = door_q;
endmodule

// File: tb/tb_elevator_car.sv
// Bench for elevator_car: a dispatcher stand-in feeds floorButtonOut back as the
// next floorButtonIn; expected stops are queued and matched at each door opening.
module tb_elevator_car;
  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] floorButtonIn;
  logic [6:0]  cabinButton;
  logic [2:0]  currentFloor;
  logic [1:0]  direction;
  logic [13:0] floorButtonOut;
  logic [6:0]  cabinPending;
  logic        doorOpen;

  elevator_car dut (
    .clk            (clk),
    .reset          (reset),
    .floorButtonIn  (floorButtonIn),
    .cabinButton    (cabinButton),
    .currentFloor   (currentFloor),
    .direction      (direction),
    .floorButtonOut (floorButtonOut),
    .cabinPending   (cabinPending),
    .doorOpen       (doorOpen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int floor;
    int dir;
    int fbo;
    int cabp;
  } stop_t;

  stop_t sb_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  prev_door = 1'b0;
  int    max_floor = 0;
  int    door_cnt;
  bit    done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: new hall calls are ORed onto the calls the car still owns.
  task automatic tick(input logic [13:0] hall, input logic [6:0] cab);
    stop_t e;
    floorButtonIn = floorButtonOut | hall;
    cabinButton   = cab;
    @(posedge clk);
    #1;
    if (int'(currentFloor) > max_floor) max_floor = int'(currentFloor);
    if (doorOpen && !prev_door) begin
      if (sb_q.size() == 0) begin
        check("unexpected_stop", currentFloor, 0);
      end else begin
        e = sb_q.pop_front();
        $display("stop floor=%0d dir=%0d fbo=%h cab=%h", currentFloor, direction,
                 floorButtonOut, cabinPending);
        check("stop_floor", currentFloor, e.floor);
        check("stop_dir", direction, e.dir);
        check("stop_fbo", floorButtonOut, e.fbo);
        check("stop_cab", cabinPending, e.cabp);
      end
    end
    prev_door = doorOpen;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(14'h0, 7'h0);
    tick(14'h0, 7'h0);
    reset = 1'b0;
    max_floor = int'(currentFloor);
  endtask

  task automatic wait_idle(input int budget, output int door_cycles, output bit ok);
    door_cycles = 0;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick(14'h0, 7'h0);
      if (doorOpen) door_cycles++;
      if (direction == 2'b00 && !doorOpen) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    floorButtonIn = '0;
    cabinButton = '0;

    // Reset values
    do_reset();
    check("rst_floor", currentFloor, 1);
    check("rst_dir", direction, 0);
    check("rst_door", doorOpen, 0);
    check("rst_fbo", floorButtonOut, 0);
    check("rst_cab", cabinPending, 0);

    // Single up-call to floor 3
    sb_q.push_back('{floor: 3, dir: 2, fbo: 0, cabp: 0});
    tick(14'h0020, 7'h0);
    check("up_dir", direction, 2);
    repeat (3) tick(14'h0, 7'h0);
    check("still_f1", currentFloor, 1);
    tick(14'h0, 7'h0);
    check("arrive_f2", currentFloor, 2);
    check("pass_f2_door", doorOpen, 0);
    repeat (4) tick(14'h0, 7'h0);
    check("arrive_f3", currentFloor, 3);
    check("f3_door", doorOpen, 1);
    check("f3_bit5", floorButtonOut[5], 0);
    tick(14'h0, 7'h0);
    check("f3_door2", doorOpen, 1);
    tick(14'h0, 7'h0);
    check("f3_door3", doorOpen, 1);
    tick(14'h0, 7'h0);
    check("f3_closed", doorOpen, 0);
    check("f3_stop_dir", direction, 0);
    check("sb_empty_up", sb_q.size(), 0);

    // Call at the current floor, then a cabin press that extends the door
    do_reset();
    sb_q.push_back('{floor: 1, dir: 0, fbo: 0, cabp: 0});
    tick(14'h0002, 7'h0);
    check("here_door", doorOpen, 1);
    check("here_floor", currentFloor, 1);
    check("here_bit1", floorButtonOut[1], 0);
    tick(14'h0, 7'h01);
    check("clear_wins", cabinPending, 0);
    wait_idle(50, door_cnt, done);
    check("door_restart_len", door_cnt, 2);
    check("here_end_floor", currentFloor, 1);
    check("sb_empty_here", sb_q.size(), 0);

    // Pass-through floor 3 going up to cabin 5, then reverse down to 3
    do_reset();
    sb_q.push_back('{floor: 5, dir: 2, fbo: 32'h10, cabp: 0});
    sb_q.push_back('{floor: 3, dir: 1, fbo: 0, cabp: 0});
    tick(14'h0, 7'h10);
    check("cab5_latched", cabinPending, 7'h10);
    tick(14'h0010, 7'h0);
    wait_idle(200, door_cnt, done);
    check("rev_end_floor", currentFloor, 3);
    check("rev_max_floor", max_floor, 5);
    check("rev_end_dir", direction, 0);
    check("sb_empty_rev", sb_q.size(), 0);

    // Top boundary: floor 7 DOWN call only
    do_reset();
    sb_q.push_back('{floor: 7, dir: 2, fbo: 0, cabp: 0});
    tick(14'h1000, 7'h0);
    wait_idle(200, door_cnt, done);
    check("top_floor", currentFloor, 7);
    check("top_max", max_floor, 7);
    check("top_dir", direction, 0);
    check("top_fbo", floorButtonOut, 0);
    check("sb_empty_top", sb_q.size(), 0);

    // Reset while travelling 2 -> 3
    do_reset();
    tick(14'h0020, 7'h0);
    done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick(14'h0, 7'h0);
      if (currentFloor == 3'd2) begin
        done = 1'b1;
        break;
      end
    end
    check("reach_f2", done, 1);
    tick(14'h0, 7'h40);
    check("mid_cab", cabinPending, 7'h40);
    reset = 1'b1;
    tick(14'h0, 7'h0);
    check("mid_rst_floor", currentFloor, 1);
    check("mid_rst_dir", direction, 0);
    check("mid_rst_fbo", floorButtonOut, 0);
    check("mid_rst_cab", cabinPending, 0);
    check("mid_rst_door", doorOpen, 0);
    reset = 1'b0;
    repeat (3) tick(14'h0, 7'h0);
    check("post_rst_dir", direction, 0);
    check("sb_empty_end", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
